// File: rtl/mips_mem_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_mem_bridge                                                          |
// | CPU load/store to 32-bit Avalon-style memory bridge with big-endian lanes |
// | Optional: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word access |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mips_mem_bridge #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata,
    input  logic        waitrequest
);

    localparam logic [2:0] c_LAT_INIT = 3'(READ_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WR    = 3'd1,
        S_RD    = 3'd2,
        S_RWAIT = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t      state_q;
    logic [2:0]  lat_cnt_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        req_ready_q, resp_valid_q, resp_error_q, read_q, write_q;
    logic [31:0] address_q, writedata_q, resp_rdata_q;
    logic [3:0]  byteenable_q;

    logic        is_word_d, is_half_d, trap_d;
    logic [1:0]  off_d, size_d;
    logic [3:0]  be_d;
    logic [31:0] wdata_d, rdata_d;
    logic [7:0]  byte_sel_d;
    logic [15:0] half_sel_d;

    // Request decode; misaligned low bits are dropped so the access stays aligned.
    always_comb begin
        is_word_d = req_size[1];
        is_half_d = (req_size == 2'd1);
        if (is_word_d) begin
            off_d   = 2'd0;
            size_d  = 2'd2;
            be_d    = 4'b1111;
            wdata_d = req_wdata;
        end else if (is_half_d) begin
            off_d   = {req_addr[1], 1'b0};
            size_d  = 2'd1;
            be_d    = req_addr[1] ? 4'b0011 : 4'b1100;
            wdata_d = {2{req_wdata[15:0]}};
        end else begin
            off_d   = req_addr[1:0];
            size_d  = 2'd0;
            be_d    = 4'b1000 >> req_addr[1:0];
            wdata_d = {4{req_wdata[7:0]}};
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap_d = (is_half_d && req_addr[0]) || (is_word_d && (req_addr[1:0] != 2'b00));
`else
    assign trap_d = 1'b0;
`endif

    always_comb begin
        case (off_q)
            2'd0:    byte_sel_d = readdata[31:24];
            2'd1:    byte_sel_d = readdata[23:16];
            2'd2:    byte_sel_d = readdata[15:8];
            default: byte_sel_d = readdata[7:0];
        endcase
        half_sel_d = off_q[1] ? readdata[15:0] : readdata[31:16];
        case (size_q)
            2'd0:    rdata_d = {{24{signed_q & byte_sel_d[7]}}, byte_sel_d};
            2'd1:    rdata_d = {{16{signed_q & half_sel_d[15]}}, half_sel_d};
            default: rdata_d = readdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lat_cnt_q    <= 3'd0;
            off_q        <= 2'd0;
            size_q       <= 2'd0;
            signed_q     <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= 32'd0;
            writedata_q  <= 32'd0;
            resp_rdata_q <= 32'd0;
            byteenable_q <= 4'd0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready_q <= 1'b0;
                        off_q       <= off_d;
                        size_q      <= size_d;
                        signed_q    <= req_signed;
                        if (trap_d) begin
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b1;
                            resp_rdata_q <= 32'd0;
                            state_q      <= S_RESP;
                        end else begin
                            address_q    <= {req_addr[31:2], 2'b00};
                            byteenable_q <= be_d;
                            writedata_q  <= wdata_d;
                            if (req_write) begin
                                write_q <= 1'b1;
                                state_q <= S_WR;
                            end else begin
                                read_q  <= 1'b1;
                                state_q <= S_RD;
                            end
                        end
                    end
                end
                S_WR: begin
                    if (!waitrequest) begin
                        write_q      <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= 32'd0;
                        state_q      <= S_RESP;
                    end
                end
                S_RD: begin
                    if (!waitrequest) begin
                        read_q    <= 1'b0;
                        lat_cnt_q <= c_LAT_INIT;
                        state_q   <= S_RWAIT;
                    end
                end
                S_RWAIT: begin
                    // Count down the fixed read latency; capture on the last edge.
                    if (lat_cnt_q <= 3'd1) begin
                        resp_rdata_q <= rdata_d;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 3'd1;
                    end
                end
                S_RESP: begin
                    resp_error_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_error = resp_error_q;
    assign address    = address_q;
    assign write      = write_q;
    assign read       = read_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;

endmodule
`default_nettype wire
